// File: rtl/regs_pkg.sv
// Shared types and constants for the multi-write-port register file.
// State encoding, default width and the RV32E/RV32I register counts.
package regs_pkg;

  typedef logic state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;

  localparam int XLEN_DEF = 32;
  localparam int NREG_E   = 16;
  localparam int NREG_I   = 32;

endpackage

// File: rtl/regs_clr_fsm.sv
// Clear walker: zeroes regs[1..NREG-1] one per cycle after reset or
// soft clear. Flags busy, the soft-clear start and the final write.
import regs_pkg::*;

module regs_clr_fsm #(
  parameter int NREG = NREG_I,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          busy_o,
  output logic [AW-1:0] idx_o,
  output logic          start_o,
  output logic          done_o
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST = AW'(1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] idx;

  // State and walk index; a soft clear restarts the walk at x1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      idx   <= FIRST;
    end else begin
      state <= state_nx;
      if (start_o)
        idx <= FIRST;
      else if (busy_o)
        idx <= idx + AW'(1);
    end
  end

  // Leave CLEAR after the last entry, re-enter on a soft clear.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == ST_CLEAR:
        if (idx == LAST) state_nx = ST_IDLE;
      state == ST_IDLE:
        if (clr_i) state_nx = ST_CLEAR;
    endcase
  end

  // Status decode from the registered state.
  always_comb begin
    busy_o  = (state == ST_CLEAR);
    start_o = (state == ST_IDLE) && clr_i;
    done_o  = busy_o && (idx == LAST);
    idx_o   = idx;
  end

endmodule

// File: rtl/regs_mp.sv
// Register file with ALU, load and bus write ports plus load scoreboard.
// Define REGS_BYPASS_EN to forward same-cycle wb writes to read ports.
import regs_pkg::*;

module regs_mp #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_I,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  output logic            busy_o,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o,
  output logic            sb_busy1_o,
  output logic            sb_busy2_o,
  input  logic            wb0_we_i,
  input  logic [AW-1:0]   wb0_addr_i,
  input  logic [XLEN-1:0] wb0_data_i,
  input  logic            wb1_we_i,
  input  logic [AW-1:0]   wb1_addr_i,
  input  logic [XLEN-1:0] wb1_data_i,
  input  logic            sb_set_i,
  input  logic [AW-1:0]   sb_addr_i,
  input  logic            bus_req_i,
  input  logic            bus_we_i,
  input  logic [AW-1:0]   bus_addr_i,
  input  logic [XLEN-1:0] bus_wdata_i,
  output logic            bus_ack_o,
  output logic [XLEN-1:0] bus_rdata_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] sb;
  logic [AW-1:0]   clr_idx;
  logic            clr_start;
  logic            clr_done;
  logic            wb0_ok;
  logic            wb1_ok;
  logic            sb_ok;
  logic            bus_acc;
  logic            bus_wr;

  regs_clr_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_i),
    .busy_o  (busy_o),
    .idx_o   (clr_idx),
    .start_o (clr_start),
    .done_o  (clr_done)
  );

  // Qualified write/accept strobes; x0 and CLEAR drop everything.
  always_comb begin
    wb0_ok  = !busy_o && wb0_we_i && (wb0_addr_i != '0);
    wb1_ok  = !busy_o && wb1_we_i && (wb1_addr_i != '0);
    sb_ok   = !busy_o && sb_set_i && (sb_addr_i != '0);
    bus_acc = !busy_o && bus_req_i && !wb0_we_i
              && !wb1_we_i && !bus_ack_o;
    bus_wr  = bus_acc && bus_we_i && (bus_addr_i != '0);
  end

  // Storage without reset; later writes win: wb1 > wb0 > bus.
  always_ff @(posedge clk) begin
    if (busy_o) begin
      regs[clr_idx] <= '0;
    end else begin
      if (bus_wr) regs[bus_addr_i] <= bus_wdata_i;
      if (wb0_ok) regs[wb0_addr_i] <= wb0_data_i;
      if (wb1_ok) regs[wb1_addr_i] <= wb1_data_i;
    end
  end

  // Bus ack pulse and captured read data (x0 forced to zero).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack_o   <= 1'b0;
      bus_rdata_o <= '0;
    end else begin
      bus_ack_o <= bus_acc;
      if (bus_acc && !bus_we_i)
        bus_rdata_o <= (bus_addr_i == '0) ? '0 : regs[bus_addr_i];
    end
  end

  // Pending-load scoreboard; set beats a same-cycle load clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (clr_start || clr_done) begin
      sb <= '0;
    end else begin
      if (wb1_ok) sb[wb1_addr_i] <= 1'b0;
      if (sb_ok)  sb[sb_addr_i]  <= 1'b1;
    end
  end

  // Read ports: registered state, optionally forwarded from wb.
  always_comb begin
    rdata1_o   = '0;
    rdata2_o   = '0;
    sb_busy1_o = !busy_o && sb[raddr1_i];
    sb_busy2_o = !busy_o && sb[raddr2_i];
    if (!busy_o && raddr1_i != '0) rdata1_o = regs[raddr1_i];
    if (!busy_o && raddr2_i != '0) rdata2_o = regs[raddr2_i];
`ifdef REGS_BYPASS_EN
    if (wb0_ok && wb0_addr_i == raddr1_i) rdata1_o = wb0_data_i;
    if (wb1_ok && wb1_addr_i == raddr1_i) rdata1_o = wb1_data_i;
    if (wb0_ok && wb0_addr_i == raddr2_i) rdata2_o = wb0_data_i;
    if (wb1_ok && wb1_addr_i == raddr2_i) rdata2_o = wb1_data_i;
    if (wb1_ok && wb1_addr_i == raddr1_i
        && !(sb_ok && sb_addr_i == raddr1_i))
      sb_busy1_o = 1'b0;
    if (wb1_ok && wb1_addr_i == raddr2_i
        && !(sb_ok && sb_addr_i == raddr2_i))
      sb_busy2_o = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp: clear walk, priority, x0, scoreboard,
// bus handshake and (when REGS_BYPASS_EN is set) forwarding.
module tb_regs_mp;

  logic        clk;
  logic        rst_n;
  logic        clr_i;
  logic        busy_o;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic        sb_busy1_o;
  logic        sb_busy2_o;
  logic        wb0_we_i;
  logic [4:0]  wb0_addr_i;
  logic [31:0] wb0_data_i;
  logic        wb1_we_i;
  logic [4:0]  wb1_addr_i;
  logic [31:0] wb1_data_i;
  logic        sb_set_i;
  logic [4:0]  sb_addr_i;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [4:0]  bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic        bus_ack_o;
  logic [31:0] bus_rdata_o;

  int ntest;
  int nfail;

  regs_mp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr_i),
    .busy_o      (busy_o),
    .raddr1_i    (raddr1_i),
    .rdata1_o    (rdata1_o),
    .raddr2_i    (raddr2_i),
    .rdata2_o    (rdata2_o),
    .sb_busy1_o  (sb_busy1_o),
    .sb_busy2_o  (sb_busy2_o),
    .wb0_we_i    (wb0_we_i),
    .wb0_addr_i  (wb0_addr_i),
    .wb0_data_i  (wb0_data_i),
    .wb1_we_i    (wb1_we_i),
    .wb1_addr_i  (wb1_addr_i),
    .wb1_data_i  (wb1_data_i),
    .sb_set_i    (sb_set_i),
    .sb_addr_i   (sb_addr_i),
    .bus_req_i   (bus_req_i),
    .bus_we_i    (bus_we_i),
    .bus_addr_i  (bus_addr_i),
    .bus_wdata_i (bus_wdata_i),
    .bus_ack_o   (bus_ack_o),
    .bus_rdata_o (bus_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wait(output logic [31:0] rd);
    int n;
    n = 0;
    step();
    while (!bus_ack_o && n < 20) begin
      step();
      n++;
    end
    check("bus_ack_seen", {31'd0, bus_ack_o}, 32'd1);
    rd = bus_rdata_o;
    bus_req_i = 1'b0;
    step();
    check("bus_ack_drop", {31'd0, bus_ack_o}, 32'd0);
  endtask

  task automatic bus_xfer(input logic we, input logic [4:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd);
    bus_we_i    = we;
    bus_addr_i  = a;
    bus_wdata_i = wd;
    bus_req_i   = 1'b1;
    bus_wait(rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int   n;
    logic ack_seen;
    ntest = 0;
    nfail = 0;
    rst_n = 1'b0;
    clr_i = 1'b0;
    raddr1_i = '0;
    raddr2_i = '0;
    wb0_we_i = 1'b0;
    wb0_addr_i = '0;
    wb0_data_i = '0;
    wb1_we_i = 1'b0;
    wb1_addr_i = '0;
    wb1_data_i = '0;
    sb_set_i = 1'b0;
    sb_addr_i = '0;
    bus_req_i = 1'b0;
    bus_we_i = 1'b0;
    bus_addr_i = '0;
    bus_wdata_i = '0;

    step();
    step();
    check("rst_busy", {31'd0, busy_o}, 32'd1);
    check("rst_ack", {31'd0, bus_ack_o}, 32'd0);
    check("rst_rdata", bus_rdata_o, 32'd0);
    check("rst_sb", {31'd0, sb_busy1_o}, 32'd0);

    // Release reset; ALU write to x5 late in the walk must be lost.
    rst_n = 1'b1;
    raddr1_i = 5'd5;
    wb0_addr_i = 5'd5;
    wb0_data_i = 32'h1234_5678;
    n = 0;
    while (busy_o && n < 100) begin
      if (n == 20) wb0_we_i = 1'b1;
      step();
      n++;
    end
    wb0_we_i = 1'b0;
    check("clr_cycles", n, 32'd31);
    #1;
    check("clr_x5", rdata1_o, 32'd0);
    step();
    check("clr_x5_idle", rdata1_o, 32'd0);

    // wb1 beats wb0 on a collision.
    wb0_we_i = 1'b1;
    wb0_addr_i = 5'd7;
    wb0_data_i = 32'h1111_1111;
    wb1_we_i = 1'b1;
    wb1_addr_i = 5'd7;
    wb1_data_i = 32'h2222_2222;
    step();
    wb0_addr_i = 5'd8;
    wb0_data_i = 32'h0000_0088;
    wb1_addr_i = 5'd6;
    wb1_data_i = 32'h0000_0066;
    raddr1_i = 5'd7;
    #1;
    check("prio_x7", rdata1_o, 32'h2222_2222);
    step();
    wb0_we_i = 1'b0;
    wb1_we_i = 1'b0;
    raddr1_i = 5'd8;
    raddr2_i = 5'd6;
    #1;
    check("par_x8", rdata1_o, 32'h0000_0088);
    check("par_x6", rdata2_o, 32'h0000_0066);

    // Bus write stalls while wb0 is writing.
    wb0_we_i = 1'b1;
    wb0_addr_i = 5'd10;
    wb0_data_i = 32'h0000_000A;
    bus_we_i = 1'b1;
    bus_addr_i = 5'd3;
    bus_wdata_i = 32'hCAFE_F00D;
    bus_req_i = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_ack_o) ack_seen = 1'b1;
    end
    check("bus_hold", {31'd0, ack_seen}, 32'd0);
    wb0_we_i = 1'b0;
    bus_wait(rd);
    bus_xfer(1'b0, 5'd3, 32'd0, rd);
    check("bus_rd_x3", rd, 32'hCAFE_F00D);
    raddr1_i = 5'd3;
    raddr2_i = 5'd10;
    #1;
    check("rd_x3", rdata1_o, 32'hCAFE_F00D);
    check("rd_x10", rdata2_o, 32'h0000_000A);

    // x0 ignores writes from every source.
    wb0_we_i = 1'b1;
    wb0_addr_i = 5'd0;
    wb0_data_i = 32'hDEAD_BEEF;
    step();
    wb0_we_i = 1'b0;
    raddr1_i = 5'd0;
    raddr2_i = 5'd0;
    #1;
    check("x0_r1", rdata1_o, 32'd0);
    check("x0_r2", rdata2_o, 32'd0);
    bus_xfer(1'b1, 5'd0, 32'h1234_5678, rd);
    bus_xfer(1'b0, 5'd0, 32'd0, rd);
    check("x0_bus", rd, 32'd0);

    // Scoreboard set, set-beats-clear, load clear, x0 ignore.
    sb_set_i = 1'b1;
    sb_addr_i = 5'd9;
    step();
    sb_set_i = 1'b0;
    raddr1_i = 5'd9;
    #1;
    check("sb_set", {31'd0, sb_busy1_o}, 32'd1);
    wb1_we_i = 1'b1;
    wb1_addr_i = 5'd9;
    wb1_data_i = 32'h0000_0099;
    sb_set_i = 1'b1;
    step();
    wb1_we_i = 1'b0;
    sb_set_i = 1'b0;
    #1;
    check("sb_setwin", {31'd0, sb_busy1_o}, 32'd1);
    check("sb_x9a", rdata1_o, 32'h0000_0099);
    wb1_we_i = 1'b1;
    wb1_data_i = 32'h0000_009A;
    step();
    wb1_we_i = 1'b0;
    #1;
    check("sb_clr", {31'd0, sb_busy1_o}, 32'd0);
    check("sb_x9b", rdata1_o, 32'h0000_009A);
    sb_set_i = 1'b1;
    sb_addr_i = 5'd0;
    step();
    sb_set_i = 1'b0;
    raddr2_i = 5'd0;
    #1;
    check("sb_x0", {31'd0, sb_busy2_o}, 32'd0);
    sb_set_i = 1'b1;
    sb_addr_i = 5'd9;
    step();
    sb_set_i = 1'b0;
    wb0_we_i = 1'b1;
    wb0_addr_i = 5'd9;
    wb0_data_i = 32'h0000_0077;
    step();
    wb0_we_i = 1'b0;
    #1;
    check("sb_wb0", {31'd0, sb_busy1_o}, 32'd1);

    // Forwarding of a same-cycle wb0 write.
    wb0_we_i = 1'b1;
    wb0_addr_i = 5'd4;
    wb0_data_i = 32'h4444_4444;
    step();
    wb0_data_i = 32'hA5A5_A5A5;
    raddr2_i = 5'd4;
    #1;
`ifdef REGS_BYPASS_EN
    check("byp_same", rdata2_o, 32'hA5A5_A5A5);
`else
    check("byp_same", rdata2_o, 32'h4444_4444);
`endif
    step();
    wb0_we_i = 1'b0;
    #1;
    check("byp_next", rdata2_o, 32'hA5A5_A5A5);

    // Soft clear; bus read issued during the walk waits for IDLE.
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("sclr_busy", {31'd0, busy_o}, 32'd1);
    bus_we_i = 1'b0;
    bus_addr_i = 5'd3;
    bus_req_i = 1'b1;
    ack_seen = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      if (bus_ack_o) ack_seen = 1'b1;
      step();
      n++;
    end
    check("sclr_cycles", n, 32'd31);
    check("sclr_noack", {31'd0, ack_seen}, 32'd0);
    bus_wait(rd);
    check("sclr_bus_x3", rd, 32'd0);
    raddr1_i = 5'd9;
    raddr2_i = 5'd4;
    #1;
    check("sclr_x9", rdata1_o, 32'd0);
    check("sclr_sb9", {31'd0, sb_busy1_o}, 32'd0);
    check("sclr_x4", rdata2_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
